stoch_window_decoder: RTL



---
 rtl/stoch_window_decoder_pkg.sv | 30 +++
 rtl/stoch_window_decoder_ones_accum.sv | 38 +++
 rtl/stoch_window_decoder.sv | 90 +++++++++
 3 files changed

// File: rtl/stoch_window_decoder_pkg.sv
// Shared types and helpers for the stochastic window decoder: FSM states,
// window length and the saturating count-to-value scaler.
package stoch_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  function automatic int unsigned win_len(input int unsigned wlog2);
    return 32'd1 << wlog2;
  endfunction

  // A full window (all ones) always maps to the maximum code.
  function automatic logic [63:0] scale_count(input logic [31:0] total,
                                              input int unsigned wlog2,
                                              input int unsigned csize);
    logic [63:0] v_max;
    logic [63:0] v_s;
    v_max = (64'd1 << csize) - 64'd1;
    if (wlog2 >= csize)
      v_s = {32'd0, total} >> (wlog2 - csize);
    else
      v_s = {32'd0, total} << (csize - wlog2);
    if ((total == win_len(wlog2)) || (v_s > v_max))
      v_s = v_max;
    return v_s;
  endfunction

endpackage

// File: rtl/stoch_window_decoder_ones_accum.sv
// En-gated sample and ones counters with last-sample detect; both counters
// clear on request and wrap to zero on the last sample of a window.
module stoch_ones_accum
  import stoch_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 i_clr,
  input  logic                 i_run,
  input  logic                 i_en,
  input  logic                 i_a,
  output logic                 o_last,
  output logic [WINDOW_LOG2:0] o_total
);

  localparam logic [WINDOW_LOG2-1:0] LAST_IDX = WINDOW_LOG2'(win_len(WINDOW_LOG2) - 1);

  logic [WINDOW_LOG2-1:0] r_smp;
  logic [WINDOW_LOG2:0]   r_ones;
  logic                   w_step;

  assign w_step  = i_run & i_en;
  assign o_last  = w_step & (r_smp == LAST_IDX);
  assign o_total = r_ones + {{WINDOW_LOG2{1'b0}}, i_a};

  always_ff @(posedge CLK) begin
    if (!nRST || i_clr || o_last) begin
      r_smp  <= '0;
      r_ones <= '0;
    end else if (w_step) begin
      r_smp  <= r_smp + WINDOW_LOG2'(1);
      r_ones <= o_total;
    end
  end

endmodule

// File: rtl/stoch_window_decoder.sv
// Stochastic bitstream decoder: counts ones over a 2^WINDOW_LOG2-sample window
// and publishes the scaled count with a one-cycle valid strobe.
module stoch_window_decoder
  import stoch_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned WINDOW_LOG2  = 8,
  parameter bit          CONTINUOUS   = 1'b0
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    en,
  input  logic                    a,
  input  logic                    start,
  output logic                    busy,
  output logic [COUNTER_SIZE-1:0] y,
  output logic                    y_valid,
  output logic                    y_sat
);

  state_t                  r_state, w_state_next;
  logic                    w_clr;
  logic                    w_last;
  logic [WINDOW_LOG2:0]    w_total;
  logic [COUNTER_SIZE-1:0] w_scaled;
  logic                    w_full;
  logic [COUNTER_SIZE-1:0] r_y;
  logic                    r_y_valid;
  logic                    r_y_sat;

  stoch_ones_accum #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_accum (
    .CLK    (CLK),
    .nRST   (nRST),
    .i_clr  (w_clr),
    .i_run  (r_state == ST_ACCUM),
    .i_en   (en),
    .i_a    (a),
    .o_last (w_last),
    .o_total(w_total)
  );

  assign w_scaled = COUNTER_SIZE'(scale_count(32'(w_total), WINDOW_LOG2, COUNTER_SIZE));
  assign w_full   = (32'(w_total) == win_len(WINDOW_LOG2));

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // start is only looked at in IDLE, so it is ignored mid-window and on the
  // completion edge of a one-shot window.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CONTINUOUS || start) begin
          w_state_next = ST_ACCUM;
          w_clr        = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (w_last && !CONTINUOUS) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_sat   <= 1'b0;
    end else begin
      r_y_valid <= w_last;
      if (w_last) begin
        r_y     <= w_scaled;
        r_y_sat <= w_full;
      end
    end
  end

  assign busy    = (r_state == ST_ACCUM);
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign y_sat   = r_y_sat;

endmodule
